inst_cache: RTL
===============

Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache. Responder on the fetch-side cache interface (valid/uncache/tag/index/offset in; addr_ok/data_ok/rdata out).
- Geometry: 256 sets × 16-byte lines (4 words), 20-bit physical tag.
- Misses and uncached fetches go to a memory-side read port feeding the AXI bridge.
- Every accepted request returns exactly one data_ok, in order.

Parameters:
CNT_W  32  width of the optional hit/miss counters

Ports:
clk        in   1   clock
resetn     in   1   asynchronous active-low reset
valid      in   1   fetch request
uncache    in   1   bypass cache (kseg1)
tag        in   20  physical address [31:12]
index      in   8   address [11:4]
offset     in   4   address [3:0]; [1:0] always 0
addr_ok    out  1   request accepted this cycle (valid & addr_ok)
data_ok    out  1   read data valid this cycle
rdata      out  32  instruction word
rd_req     out  1   memory read request
rd_type    out  1   0 = single word, 1 = 4-word line
rd_addr    out  32  memory read address
rd_rdy     in   1   memory accepted rd_req this cycle
ret_valid  in   1   return beat valid
ret_last   in   1   last return beat
ret_data   in   32  return beat data

Behaviour:
- Storage:
  - valid[255:0] cleared by resetn; tag and data arrays are not reset.
  - Arrays read asynchronously on index, written synchronously.
- Request register captures {uncache, tag, index, offset} on valid & addr_ok.
- States: IDLE, LOOKUP, MISS, REFILL, UNC_REQ, UNC_WAIT.
- IDLE:
  - addr_ok = 1.
  - valid → LOOKUP if uncache = 0, else UNC_REQ.
- LOOKUP:
  - hit = valid[idx] & tag_arr[idx] == req_tag.
  - On hit: data_ok = 1, rdata = data word offset[3:2].
  - On hit, addr_ok = 1, so a new request can be accepted the same cycle. New cached request → stay in LOOKUP; new uncached → UNC_REQ; none → IDLE.
  - On miss: addr_ok = 0, data_ok = 0, → MISS.
- MISS:
  - rd_req = 1, rd_type = 1, rd_addr = {req_tag, req_index, 4'b0}.
  - Held stable until rd_rdy; then → REFILL.
- REFILL:
  - Beat counter 0..3 advances on each ret_valid; beat k writes data word k.
  - The requested word (beat == offset[3:2]) is latched.
  - On ret_valid & ret_last: write tag, set valid[idx], data_ok = 1, rdata = latched word (or ret_data if this beat is the requested one), → IDLE.
- UNC_REQ:
  - rd_req = 1, rd_type = 0, rd_addr = {req_tag, req_index, req_offset}.
  - On rd_rdy → UNC_WAIT.
- UNC_WAIT:
  - On ret_valid: data_ok = 1, rdata = ret_data, → IDLE.
  - No array write; valid bits untouched even if the address is cached.
- addr_ok is 0 in MISS, REFILL, UNC_REQ and UNC_WAIT; a requester holding valid waits.
- Latency:
  - Hit: data_ok 1 cycle after acceptance; sustained 1 hit/cycle.
  - Miss: data_ok in the cycle of ret_last.
- No cancel input. The requester discards stale data itself, so data_ok must still be delivered for every accepted request.
- Reset values (any time, including mid-refill):
  - State = IDLE, all valid bits = 0, beat counter = 0, counters = 0.
  - addr_ok = 1 after release; data_ok = 0, rd_req = 0, rd_type = 0, rd_addr = 0, rdata = 0.
  - A partially filled line is never marked valid.
- Beats arriving in IDLE or LOOKUP (protocol violation) are ignored.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined:
  - Outputs hit_cnt[CNT_W-1:0] and miss_cnt[CNT_W-1:0].
  - hit_cnt increments on each LOOKUP hit; miss_cnt increments on each LOOKUP→MISS transition.
  - Uncached accesses are not counted; counters wrap at 2^CNT_W; both reset to 0.
- Not defined: the ports and logic are absent, and the rest of the behaviour is identical.

Test Plan:
- Cold miss → line fill:
  - Stimulus: after reset, request tag 0x1FC00, index 0x00, offset 0x4, cached; return beats 0x11, 0x22, 0x33, 0x44 (last on the 4th).
  - Required: rd_req with rd_type = 1, rd_addr = 0x1FC00000; data_ok with rdata = 0x22 on the ret_last cycle; valid[0] = 1.
- Back-to-back hits:
  - Stimulus: then requests offsets 0x0, 0x8, 0xC on consecutive cycles.
  - Required: addr_ok = 1 on each cycle; data_ok on 3 consecutive cycles with 0x11, 0x33, 0x44; no rd_req.
- Uncached bypass:
  - Stimulus: uncache = 1, address 0x1FC00008; return 0xDEADBEEF.
  - Required: rd_type = 0, rd_addr = 0x1FC00008; data_ok with 0xDEADBEEF; a following cached read of the same address hits with 0x33.
- Conflict eviction:
  - Stimulus: cached read of tag 0x00001, index 0x00.
  - Required: miss and refill; a subsequent tag 0x1FC00 read misses again.
- Stall under rd_rdy = 0:
  - Stimulus: miss while rd_rdy is held 0 for 5 cycles.
  - Required: rd_req and rd_addr stay stable; addr_ok = 0 throughout; a new valid is accepted only after data_ok.
- Reset mid-refill:
  - Stimulus: assert resetn = 0 after 2 beats.
  - Required: state IDLE, rd_req = 0, data_ok = 0; the same address misses after release.
  - With ICACHE_PERF_CNT_EN: counters read 0.

Source files
------------

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped, read-only instruction cache.
//   256 sets x 16-byte lines (4 words), 20-bit physical tag.
//   Misses fetch a 4-word line through the memory read port; uncached fetches
//   go through it as single-word reads. Each accepted request gets exactly
//   one data_ok, in order.
//
// Ports
//   clk, resetn                     clock, async active-low reset
//   valid/uncache/tag/index/offset  fetch request in
//   addr_ok/data_ok/rdata           fetch handshake and instruction word out
//   rd_req/rd_type/rd_addr/rd_rdy   memory read request (rd_type 1 = line)
//   ret_valid/ret_last/ret_data     memory return beats
//   hit_cnt/miss_cnt                only when ICACHE_PERF_CNT_EN is defined
//
// Optional feature: define ICACHE_PERF_CNT_EN to add the hit/miss counters.
//
// state    | meaning
// IDLE     | no request outstanding, accepting
// LOOKUP   | compare tag of captured request; hit returns data
// MISS     | line read request presented, waiting for rd_rdy
// REFILL   | receiving 4 line beats
// UNC_REQ  | single-word read request presented, waiting for rd_rdy
// UNC_WAIT | waiting for the single uncached beat
module inst_cache #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid,
  input  logic             uncache,
  input  logic [19:0]      tag,
  input  logic [7:0]       index,
  input  logic [3:0]       offset,
  output logic             addr_ok,
  output logic             data_ok,
  output logic [31:0]      rdata,
  output logic             rd_req,
  output logic             rd_type,
  output logic [31:0]      rd_addr,
  input  logic             rd_rdy,
  input  logic             ret_valid,
  input  logic             ret_last,
  input  logic [31:0]      ret_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MISS, REFILL, UNC_REQ, UNC_WAIT
  } state_t;

  state_t      state_q, state_d;

  logic        req_unc_q;
  logic [19:0] req_tag_q;
  logic [7:0]  req_idx_q;
  logic [3:0]  req_off_q;

  logic [255:0] valid_q;
  logic [19:0]  tag_arr  [256];
  logic [31:0]  data_arr [256][4];

  logic [1:0]  beat_q;
  logic [31:0] word_q;

  logic hit;
  logic accept;
  logic fill_beat;
  logic fill_last;

  assign hit       = valid_q[req_idx_q] && (tag_arr[req_idx_q] == req_tag_q);
  assign accept    = valid && addr_ok;
  assign fill_beat = (state_q == REFILL) && ret_valid;
  assign fill_last = fill_beat && ret_last;

  always_comb begin
    state_d = state_q;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    rdata   = 32'h0;
    rd_req  = 1'b0;
    rd_type = 1'b0;
    rd_addr = 32'h0;
    case (state_q)
      IDLE: begin
        addr_ok = 1'b1;
        if (valid) state_d = uncache ? UNC_REQ : LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          data_ok = 1'b1;
          rdata   = data_arr[req_idx_q][req_off_q[3:2]];
          addr_ok = 1'b1;
          if (valid) state_d = uncache ? UNC_REQ : LOOKUP;
          else       state_d = IDLE;
        end else begin
          state_d = MISS;
        end
      end
      MISS: begin
        rd_req  = 1'b1;
        rd_type = 1'b1;
        rd_addr = {req_tag_q, req_idx_q, 4'b0000};
        if (rd_rdy) state_d = REFILL;
      end
      REFILL: begin
        if (fill_last) begin
          data_ok = 1'b1;
          // the requested word may be arriving on this very beat
          rdata   = (beat_q == req_off_q[3:2]) ? ret_data : word_q;
          state_d = IDLE;
        end
      end
      UNC_REQ: begin
        rd_req  = 1'b1;
        rd_addr = {req_tag_q, req_idx_q, req_off_q};
        if (rd_rdy) state_d = UNC_WAIT;
      end
      UNC_WAIT: begin
        if (ret_valid) begin
          data_ok = 1'b1;
          rdata   = ret_data;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      req_unc_q <= 1'b0;
      req_tag_q <= 20'h0;
      req_idx_q <= 8'h0;
      req_off_q <= 4'h0;
      valid_q   <= '0;
      beat_q    <= 2'd0;
      word_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_unc_q <= uncache;
        req_tag_q <= tag;
        req_idx_q <= index;
        req_off_q <= offset;
      end
      if (fill_beat) begin
        if (beat_q == req_off_q[3:2]) word_q <= ret_data;
        beat_q <= fill_last ? 2'd0 : beat_q + 2'd1;
      end
      // valid is set only on the final beat, so an aborted fill never counts
      if (fill_last) valid_q[req_idx_q] <= 1'b1;
    end
  end

  // storage arrays are not reset; reset forces IDLE so no write can occur
  always_ff @(posedge clk) begin
    if (fill_beat) begin
      data_arr[req_idx_q][beat_q] <= ret_data;
      if (ret_last) tag_arr[req_idx_q] <= req_tag_q;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 1'b1;
      else     miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  // uncached flag is only needed at acceptance; keep it for debug visibility
  logic unused_ok;
  assign unused_ok = req_unc_q;

endmodule
